// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: divider state encoding, default datapath width
// and the quotient reported when the divisor is zero.
package cpu_pkg;

    localparam int CPU_WIDTH = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } div_state_t;

    localparam logic [CPU_WIDTH-1:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/alu_sub_stage.sv
// Combinational trial subtractor built from ripple add slices with B inverted and
// carry-in forced high, so it matches the ALU subtract path bit for bit.
module alu_sub_stage #(
    parameter int N = 17
) (
    input  logic [N-1:0] t,
    input  logic [N-1:0] d,
    output logic [N-1:0] diff,
    output logic         cout
);

    logic [N:0] carry;

    assign carry[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_slice
            logic b_eff;
            assign b_eff       = ~d[gi];
            assign diff[gi]    = t[gi] ^ b_eff ^ carry[gi];
            assign carry[gi+1] = (t[gi] & b_eff) | (t[gi] & carry[gi]) | (b_eff & carry[gi]);
        end
    endgenerate

    // Carry out of the top slice is the "no borrow" indication.
    assign cout = carry[N];

endmodule

// File: rtl/alu_div16.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, with a
// busy/done handshake and a divide-by-zero shortcut that skips iteration.
module alu_div16
    import cpu_pkg::*;
#(
    parameter int WIDTH = CPU_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    div_state_t       state_reg;
    logic [CNT_W-1:0] count_reg;
    logic [WIDTH:0]   p_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH-1:0] quotient_reg;
    logic [WIDTH-1:0] remainder_reg;
    logic             dbz_reg;
    logic             busy_reg;
    logic             done_reg;

    logic [WIDTH:0]   t_val;
    logic [WIDTH:0]   diff_val;
    logic             cout_val;
    logic [WIDTH:0]   p_next;
    logic [WIDTH-1:0] q_next;
    logic             last_step;

    // The partial remainder stays below the divisor, so its top bit is never read.
    logic unused_p_msb;
    assign unused_p_msb = p_reg[WIDTH];

    assign t_val = {p_reg[WIDTH-1:0], q_reg[WIDTH-1]};

    alu_sub_stage #(
        .N(WIDTH + 1)
    ) u_sub (
        .t    (t_val),
        .d    ({1'b0, d_reg}),
        .diff (diff_val),
        .cout (cout_val)
    );

    assign p_next    = cout_val ? diff_val : t_val;
    assign q_next    = {q_reg[WIDTH-2:0], cout_val};
    assign last_step = (count_reg == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= S_IDLE;
            count_reg     <= '0;
            p_reg         <= '0;
            q_reg         <= '0;
            d_reg         <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE, S_DONE: begin
                    done_reg <= 1'b0;
                    busy_reg <= 1'b0;
                    state_reg <= S_IDLE;
                    if (start) begin
                        if (divisor == '0) begin
                            state_reg     <= S_DONE;
                            done_reg      <= 1'b1;
                            quotient_reg  <= {WIDTH{DIV0_QUOTIENT[0]}};
                            remainder_reg <= dividend;
                            dbz_reg       <= 1'b1;
                        end else begin
                            state_reg <= S_RUN;
                            busy_reg  <= 1'b1;
                            count_reg <= '0;
                            p_reg     <= '0;
                            q_reg     <= dividend;
                            d_reg     <= divisor;
                        end
                    end
                end
                S_RUN: begin
                    p_reg     <= p_next;
                    q_reg     <= q_next;
                    count_reg <= count_reg + 1'b1;
                    if (last_step) begin
                        quotient_reg  <= q_next;
                        remainder_reg <= p_next[WIDTH-1:0];
                        dbz_reg       <= 1'b0;
                        busy_reg      <= 1'b0;
                        done_reg      <= 1'b1;
                        state_reg     <= S_DONE;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_reg;
    assign done        = done_reg;
    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;
    assign div_by_zero = dbz_reg;

endmodule
